// File: rtl/spi_slave_byte.sv
// spi_slave_byte: oversampled SPI slave that exchanges bytes with rx/tx FIFOs in the sclk_common domain
module spi_slave_byte #(
  parameter bit CPOL = 1'b0,
  parameter bit CPHA = 1'b0,
  parameter logic [7:0] IDLE_BYTE = 8'hFF
) (
  input  logic       n_rst,
  input  logic       sclk_common,
  input  logic       spi_sclk,
  input  logic       spi_n_cs,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       miso_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_empty,
  output logic       tx_rdreq,
  output logic [7:0] rx_data,
  output logic       rx_wrreq,
  output logic [7:0] byte_cnt,
  output logic       frame_end,
  output logic       tx_underrun
);
  localparam logic [0:0] IDLE = 1'b0, ACTIVE = 1'b1;
  logic [2:0] sclk_sr, cs_sr, bit_cnt;
  logic [1:0] mosi_sr, cs_vld;
  logic cs_armed, first_edge, rise, fall, samp, shft, cs_fall, cs_rise, load;
  logic [0:0] state;
  logic [7:0] tx_shift, rx_shift;
  // A frame may only start from a falling n_cs that was genuinely seen high after reset
  always_ff @(posedge sclk_common or negedge n_rst)
    if (!n_rst) begin
      sclk_sr <= {3{CPOL}};
      cs_sr <= 3'b111;
      mosi_sr <= 2'b00;
      cs_vld <= 2'b00;
      cs_armed <= 1'b0;
    end else begin
      sclk_sr <= {sclk_sr[1:0], spi_sclk};
      cs_sr <= {cs_sr[1:0], spi_n_cs};
      mosi_sr <= {mosi_sr[0], spi_mosi};
      cs_vld <= {cs_vld[0], 1'b1};
      cs_armed <= cs_armed | (cs_vld[1] & cs_sr[1]);
    end
  always_comb begin
    rise = sclk_sr[1] & ~sclk_sr[2];
    fall = ~sclk_sr[1] & sclk_sr[2];
    samp = (CPOL == CPHA) ? rise : fall;
    shft = (CPOL == CPHA) ? fall : rise;
    cs_fall = cs_armed & ~cs_sr[1] & cs_sr[2];
    cs_rise = cs_sr[1] & ~cs_sr[2];
    load = (state == IDLE) ? cs_fall : (~cs_rise & shft & ~(CPHA & first_edge) & (bit_cnt == 3'd0));
  end
  assign spi_miso = tx_shift[7];
  always_ff @(posedge sclk_common or negedge n_rst)
    if (!n_rst) begin
      state <= IDLE;
      tx_shift <= IDLE_BYTE;
      rx_shift <= 8'h00;
      bit_cnt <= 3'd0;
      first_edge <= 1'b0;
      miso_oe <= 1'b0;
      tx_rdreq <= 1'b0;
      tx_underrun <= 1'b0;
      rx_data <= 8'h00;
      rx_wrreq <= 1'b0;
      byte_cnt <= 8'h00;
      frame_end <= 1'b0;
    end else begin
      tx_rdreq <= 1'b0;
      tx_underrun <= 1'b0;
      rx_wrreq <= 1'b0;
      frame_end <= 1'b0;
      if (load) begin
        tx_shift <= tx_empty ? IDLE_BYTE : tx_data;
        tx_rdreq <= ~tx_empty;
        tx_underrun <= tx_empty;
      end
      if (state == IDLE) begin
        if (cs_fall) begin
          state <= ACTIVE;
          miso_oe <= 1'b1;
          bit_cnt <= 3'd0;
          byte_cnt <= 8'h00;
          first_edge <= 1'b1;
        end
      end else if (cs_rise) begin
        state <= IDLE;
        miso_oe <= 1'b0;
        frame_end <= 1'b1;
      end else if (samp) begin
        rx_shift <= {rx_shift[6:0], mosi_sr[1]};
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          rx_data <= {rx_shift[6:0], mosi_sr[1]};
          rx_wrreq <= 1'b1;
          byte_cnt <= (byte_cnt == 8'hFF) ? byte_cnt : byte_cnt + 8'd1;
        end
      end else if (shft) begin
        if (CPHA && first_edge) first_edge <= 1'b0;
        else if (bit_cnt != 3'd0) tx_shift <= {tx_shift[6:0], 1'b0};
      end
    end
endmodule

// File: tb/tb_spi_slave_byte.sv
// tb_spi_slave_byte: drives three slaves (modes 0, 1, 3) with a behavioural SPI master and FIFO model
module tb_spi_slave_byte;
  localparam int H = 6;
  logic clk = 1'b0, n_rst;
  logic [2:0] sclk, ncs, mosi, spi_miso, miso_oe, tx_empty, tx_rdreq, rx_wrreq, frame_end, tx_underrun;
  logic [7:0] tx_data [3];
  logic [7:0] rx_data [3];
  logic [7:0] byte_cnt [3];
  logic [7:0] mem [3][256];
  logic [7:0] rd [3] = '{8'd0, 8'd0, 8'd0};
  logic [7:0] wr [3] = '{8'd0, 8'd0, 8'd0};
  logic [7:0] mbytes [300];
  logic [7:0] mrx [300];
  logic [15:0] exp_q [3][$];
  logic [15:0] e;
  logic [3:0] s;
  logic [3:0] prev [3] = '{4'd0, 4'd0, 4'd0};
  int n_wr [3] = '{0, 0, 0};
  int n_rd [3] = '{0, 0, 0};
  int n_un [3] = '{0, 0, 0};
  int n_fe [3] = '{0, 0, 0};
  int tests = 0, fails = 0;
  int s_wr, s_rd, s_un, s_fe;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : gd
    spi_slave_byte #(.CPOL(g == 2), .CPHA(g != 0), .IDLE_BYTE(8'hFF)) u (
      .n_rst(n_rst), .sclk_common(clk), .spi_sclk(sclk[g]), .spi_n_cs(ncs[g]), .spi_mosi(mosi[g]),
      .spi_miso(spi_miso[g]), .miso_oe(miso_oe[g]), .tx_data(tx_data[g]), .tx_empty(tx_empty[g]),
      .tx_rdreq(tx_rdreq[g]), .rx_data(rx_data[g]), .rx_wrreq(rx_wrreq[g]), .byte_cnt(byte_cnt[g]),
      .frame_end(frame_end[g]), .tx_underrun(tx_underrun[g]));
    assign tx_data[g] = mem[g][rd[g]];
    assign tx_empty[g] = rd[g] == wr[g];
    always @(posedge clk) if (tx_rdreq[g]) rd[g] <= rd[g] + 8'd1;
  end
  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  // Scoreboard: each received byte must match the master's queue, with byte_cnt saturating at 255
  always @(negedge clk) begin
    for (int g = 0; g < 3; g++) begin
      s = {rx_wrreq[g], tx_rdreq[g], tx_underrun[g], frame_end[g]};
      if (rx_wrreq[g]) begin
        chk("rx_expected", int'(exp_q[g].size() > 0), 1);
        if (exp_q[g].size() > 0) begin
          e = exp_q[g].pop_front();
          chk("rx_byte_cnt", {byte_cnt[g], rx_data[g]}, e);
        end
        n_wr[g]++;
      end
      if (tx_rdreq[g]) n_rd[g]++;
      if (tx_underrun[g]) n_un[g]++;
      if (frame_end[g]) n_fe[g]++;
      if (tx_rdreq[g] | tx_underrun[g]) chk("rd_und_excl", tx_rdreq[g] & tx_underrun[g], 0);
      if (s != 4'd0) chk("strobe_width", s & prev[g], 0);
      prev[g] = s;
    end
  end
  task automatic push_tx(input int g, input logic [7:0] b);
    mem[g][wr[g]] = b;
    wr[g] = wr[g] + 8'd1;
  endtask
  task automatic snap(input int g);
    s_wr = n_wr[g]; s_rd = n_rd[g]; s_un = n_un[g]; s_fe = n_fe[g];
  endtask
  task automatic xfer(input int g, input int nbits);
    logic b;
    int k;
    ncs[g] = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      b = mbytes[i / 8][7 - i % 8];
      k = i / 8 + 1;
      if (i % 8 == 7) exp_q[g].push_back({(k > 255) ? 8'd255 : 8'(k), mbytes[i / 8]});
      if (g == 0) mosi[g] = b;
      repeat (H) @(negedge clk);
      sclk[g] = ~sclk[g];
      if (g == 0) mrx[i / 8][7 - i % 8] = spi_miso[g];
      else mosi[g] = b;
      repeat (H) @(negedge clk);
      sclk[g] = ~sclk[g];
      if (g != 0) mrx[i / 8][7 - i % 8] = spi_miso[g];
    end
    repeat (H) @(negedge clk);
    ncs[g] = 1'b1;
    repeat (8) @(negedge clk);
  endtask
  initial begin
    n_rst = 1'b0; sclk = 3'b100; ncs = 3'b111; mosi = 3'b000;
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      chk("rst_miso", spi_miso[g], 1);
      chk("rst_oe", miso_oe[g], 0);
      chk("rst_rx_data", rx_data[g], 0);
      chk("rst_byte_cnt", byte_cnt[g], 0);
    end
    push_tx(0, 8'h5A); push_tx(0, 8'hC3); push_tx(0, 8'h11);
    mbytes[0] = 8'hA5; mbytes[1] = 8'h3C;
    snap(0);
    xfer(0, 16);
    chk("m0_miso0", mrx[0], 8'h5A);
    chk("m0_miso1", mrx[1], 8'hC3);
    chk("m0_rdreq", n_rd[0] - s_rd, 3);
    chk("m0_wrreq", n_wr[0] - s_wr, 2);
    chk("m0_byte_cnt", byte_cnt[0], 2);
    chk("m0_frame_end", n_fe[0] - s_fe, 1);
    chk("m0_oe_after", miso_oe[0], 0);
    chk("m0_q_drained", exp_q[0].size(), 0);
    ncs[0] = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      repeat (H) @(negedge clk);
      sclk[0] = 1'b1;
      repeat (H) @(negedge clk);
      sclk[0] = 1'b0;
    end
    chk("rst_mid_oe_before", miso_oe[0], 1);
    n_rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_oe", miso_oe[0], 0);
    chk("rst_mid_miso", spi_miso[0], 1);
    chk("rst_mid_rx_data", rx_data[0], 0);
    chk("rst_mid_byte_cnt", byte_cnt[0], 0);
    chk("rst_mid_strobes", {tx_rdreq[0], rx_wrreq[0], frame_end[0], tx_underrun[0]}, 0);
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    snap(0);
    repeat (20) @(negedge clk);
    chk("rst_cs_low_oe", miso_oe[0], 0);
    chk("rst_cs_low_loads", (n_rd[0] - s_rd) + (n_un[0] - s_un), 0);
    ncs[0] = 1'b1;
    repeat (10) @(negedge clk);
    mbytes[0] = 8'h3C;
    xfer(0, 8);
    chk("rst_next_rx", rx_data[0], 8'h3C);
    chk("rst_next_byte_cnt", byte_cnt[0], 1);
    mbytes[0] = 8'h00;
    snap(0);
    xfer(0, 8);
    chk("empty_miso", mrx[0], 8'hFF);
    chk("empty_underrun", n_un[0] - s_un, 2);
    chk("empty_rdreq", n_rd[0] - s_rd, 0);
    chk("empty_rx", rx_data[0], 8'h00);
    mbytes[0] = 8'hFF;
    snap(1);
    xfer(1, 5);
    chk("abort_wrreq", n_wr[1] - s_wr, 0);
    chk("abort_byte_cnt", byte_cnt[1], 0);
    chk("abort_frame_end", n_fe[1] - s_fe, 1);
    mbytes[0] = 8'h96;
    xfer(1, 8);
    chk("abort_next_rx", rx_data[1], 8'h96);
    chk("abort_next_byte_cnt", byte_cnt[1], 1);
    push_tx(2, 8'h7E);
    mbytes[0] = 8'h81;
    snap(2);
    xfer(2, 8);
    chk("m3_miso", mrx[0], 8'h7E);
    chk("m3_rx", rx_data[2], 8'h81);
    chk("m3_rdreq", n_rd[2] - s_rd, 1);
    chk("m3_byte_cnt", byte_cnt[2], 1);
    for (int i = 0; i < 260; i++) mbytes[i] = 8'(i * 7 + 3);
    snap(0);
    xfer(0, 2080);
    chk("sat_byte_cnt", byte_cnt[0], 255);
    chk("sat_wrreq", n_wr[0] - s_wr, 260);
    chk("sat_q_drained", exp_q[0].size(), 0);
    chk("sat_frame_end", n_fe[0] - s_fe, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
